// File: rtl/fmap_win_buf.sv
// Feature-map window buffer: raster writes fill a bank, then a scan emits every KxK window (stride 1).
// Define FMAP_WIN_BUF_PINGPONG_EN for two ping-pong banks; the default build has a single bank.
module fmap_win_buf #(
   parameter int DW    = 18,
   parameter int MAP_W = 11,
   parameter int MAP_H = 11,
   parameter int K     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic [DW-1:0]     din,
   output logic              wr_rdy,
   input  logic              start,
   output logic              busy,
   output logic              win_vld,
   input  logic              win_rdy,
   output logic [K*K*DW-1:0] win_data,
   output logic              win_last,
   output logic              done
);
   localparam int N  = MAP_W * MAP_H;
`ifdef FMAP_WIN_BUF_PINGPONG_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif
   localparam int AW = (NB * N > 1) ? $clog2(NB * N) : 1;
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int RW = $clog2(MAP_H + 1);
   localparam int CW = $clog2(MAP_W + 1);
   localparam logic [RW-1:0] R_LAST = RW'(MAP_H - K);
   localparam logic [CW-1:0] C_LAST = CW'(MAP_W - K);
   localparam logic [PW-1:0] P_LAST = PW'(N - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   logic [DW-1:0]      mem [NB*N];
   state_t             state_q, state_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [1:0]         full_q, full_d;
   logic               wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [RW-1:0]      row_q, row_d, ld_r;
   logic [CW-1:0]      col_q, col_d, ld_c;
   logic               win_vld_q, win_vld_d, win_last_q, win_last_d, done_q, done_d;
   logic [K*K*DW-1:0]  win_data_q, win_data_d, win_rd;
   logic               wr_fire, hs, start_ok, load;

`ifdef FMAP_WIN_BUF_PINGPONG_EN
   assign wr_rdy = ~&full_q;
`else
   assign wr_rdy = ~|full_q;
`endif
   assign busy     = (state_q == SCAN);
   assign win_vld  = win_vld_q;
   assign win_last = win_last_q;
   assign win_data = win_data_q;
   assign done     = done_q;

   assign wr_fire  = wr & wr_rdy;
   assign hs       = win_vld_q & win_rdy;
   // start is judged against registered full state, so a bank completing this cycle cannot be scanned yet
   assign start_ok = start && (state_q == IDLE) && full_q[rd_bank_q];

   always_ff @(posedge clk) begin
      if (wr_fire) mem[AW'(int'(wr_bank_q) * N + int'(wr_ptr_q))] <= din;
   end

   // Origin of the window to capture this cycle: (0,0) on start, next origin on a handshake
   always_comb begin
      load = 1'b0;
      ld_r = '0;
      ld_c = '0;
      if (start_ok) begin
         load = 1'b1;
      end else if (hs && !win_last_q) begin
         load = 1'b1;
         if (col_q == C_LAST) begin
            ld_r = row_q + 1'b1;
         end else begin
            ld_r = row_q;
            ld_c = col_q + 1'b1;
         end
      end
   end

   genvar gi, gj;
   generate
      for (gi = 0; gi < K; gi++) begin : g_row
         for (gj = 0; gj < K; gj++) begin : g_col
            assign win_rd[(gi*K+gj)*DW +: DW] =
               mem[AW'(int'(rd_bank_q) * N + (int'(ld_r) + gi) * MAP_W + int'(ld_c) + gj)];
         end
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      full_d     = full_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      row_d      = row_q;
      col_d      = col_q;
      win_vld_d  = win_vld_q;
      win_last_d = win_last_q;
      win_data_d = win_data_q;
      done_d     = 1'b0;

      if (wr_fire) begin
         if (wr_ptr_q == P_LAST) begin
            wr_ptr_d          = '0;
            full_d[wr_bank_q] = 1'b1;
`ifdef FMAP_WIN_BUF_PINGPONG_EN
            wr_bank_d         = ~wr_bank_q;
`endif
         end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
      end

      if (start_ok) begin
         state_d   = SCAN;
         win_vld_d = 1'b1;
      end else if (hs && win_last_q) begin
         state_d           = IDLE;
         win_vld_d         = 1'b0;
         win_last_d        = 1'b0;
         done_d            = 1'b1;
         full_d[rd_bank_q] = 1'b0;
`ifdef FMAP_WIN_BUF_PINGPONG_EN
         rd_bank_d         = ~rd_bank_q;
`endif
      end

      if (load) begin
         row_d      = ld_r;
         col_d      = ld_c;
         win_last_d = (ld_r == R_LAST) && (ld_c == C_LAST);
         win_data_d = win_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         full_q     <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         win_vld_q  <= 1'b0;
         win_last_q <= 1'b0;
         win_data_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         full_q     <= full_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         row_q      <= row_d;
         col_q      <= col_d;
         win_vld_q  <= win_vld_d;
         win_last_q <= win_last_d;
         win_data_q <= win_data_d;
         done_q     <= done_d;
      end
   end
endmodule

// File: doc/fmap_win_buf.md
FMAP_WIN_BUF -- requirements
Module: fmap_win_buf

Interface
REQ-001 SHALL have parameter DW, 18, data word width in bits.
REQ-002 SHALL have parameter MAP_W, 11, feature-map width in words.
REQ-003 SHALL have parameter MAP_H, 11, feature-map height in words.
REQ-004 SHALL have parameter K, 2, square window edge; 1 <= K <= min(MAP_W, MAP_H).
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port wr, input, 1, write strobe; accepted only when wr_rdy=1.
REQ-008 SHALL have port din, input, DW, write data in raster order (row-major).
REQ-009 SHALL have port wr_rdy, output, 1, a bank is available to accept writes.
REQ-010 SHALL have port start, input, 1, single-cycle request to scan a full bank.
REQ-011 SHALL have port busy, output, 1, a scan is in progress.
REQ-012 SHALL have port win_vld, output, 1, win_data is valid.
REQ-013 SHALL have port win_rdy, input, 1, consumer accepts the window.
REQ-014 SHALL have port win_data, output, K*K*DW, window; element (i,j) at [(i*K+j)*DW +: DW].
REQ-015 SHALL have port win_last, output, 1, qualifies the final window of a scan.
REQ-016 SHALL have port done, output, 1, one-cycle pulse after the final window handshake.

Function
REQ-017 SHALL store MAP_W*MAP_H words per bank; the write pointer SHALL increment on each accepted write, wrap to 0 after MAP_W*MAP_H-1, and mark the bank full.
REQ-018 SHALL ignore wr while wr_rdy=0 (no pointer or memory change).
REQ-019 SHALL run FSM IDLE -> SCAN on start when at least one bank is full and busy=0; start in any other condition SHALL be ignored.
REQ-020 SHALL scan window origins (r,c), r in 0..MAP_H-K, c in 0..MAP_W-K, c fastest, stride 1: (MAP_W-K+1)*(MAP_H-K+1) windows.
REQ-021 SHALL set win_data element (i,j) = bank[(r+i)*MAP_W + c+j].
REQ-022 SHALL assert win_vld for the first window exactly 1 cycle after the accepted start (registered output).
REQ-023 SHALL hold win_data, win_last and win_vld stable while win_vld=1 and win_rdy=0.
REQ-024 SHALL advance to the next window on win_vld&&win_rdy, with the next win_vld in the following cycle (1 window/cycle sustained).
REQ-025 SHALL assert win_last only with origin (MAP_H-K, MAP_W-K); on its handshake it SHALL pulse done, release the bank (not full), return to IDLE, and deassert win_vld.
REQ-026 SHALL, when a write completes a bank in the same cycle as start, not accept that start (start is sampled against registered full state).
REQ-027 SHALL, for K=1, emit each stored word as a window with win_last on address MAP_W*MAP_H-1.

Reset
REQ-028 SHALL on rst_n=0 asynchronously clear write pointer, scan counters, bank-full flags and FSM (IDLE).
REQ-029 SHALL reset outputs to: wr_rdy=1, busy=0, win_vld=0, win_last=0, done=0, win_data=0.
REQ-030 SHALL NOT reset memory contents; reset mid-scan or mid-fill SHALL discard that scan/fill.

Configuration
REQ-031 SHALL compile two banks (ping-pong) when macro FMAP_WIN_BUF_PINGPONG_EN is defined: writes fill the non-scanned bank, wr_rdy=1 while fewer than 2 banks are full, scans consume full banks in fill order.
REQ-032 SHALL compile a single bank when FMAP_WIN_BUF_PINGPONG_EN is undefined: wr_rdy=0 from bank-full until the scan's done pulse.

Verification
REQ-033 Defaults, write din=0..120, start, win_rdy=1 -> first window {0,1,11,12} 1 cycle after start, 100 windows, last {108,109,119,120} with win_last, done next cycle.
REQ-034 Same fill, win_rdy low for 3 cycles at window 5 (origin 0,5) -> win_data {5,6,16,17} held stable, no window skipped or duplicated.
REQ-035 Single bank: 121 writes then wr with din=999 -> wr_rdy=0, write ignored, scan output unchanged; start before fill -> ignored, busy=0.
REQ-036 PINGPONG_EN: fill bank0 with 0..120, start, concurrently write 1000..1120 -> second scan first window {1000,1001,1011,1012}; wr_rdy=0 only when both banks full.
REQ-037 rst_n low during window 40 -> win_vld=0, busy=0, wr_rdy=1 immediately; refill and rescan -> correct 100 windows.
REQ-038 K=3, MAP_W=MAP_H=5, din=0..24 -> 9 windows, first {0,1,2,5,6,7,10,11,12}, last origin (2,2) with win_last.
